// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter feeding one shared APB transaction FIFO from NUM_REQ requesters.
// Latency: grant in cycle N appears on fifo_wr_en/fifo_din/grant_id in cycle N+1.
// Backpressure: req_ready is withheld while no FIFO credit is free (or while another requester holds the lock).
// Optional feature macro: ARB_LOCK_EN (per-requester lock for atomic read-modify-write sequences).
module apb_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ENTRY_W    = 66,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ENTRY_W-1:0]    req_data,
    input  logic [NUM_REQ-1:0]            req_lock,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [ENTRY_W-1:0]            fifo_din,
    input  logic                          fifo_pop,
    input  logic                          fifo_full,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic [$clog2(FIFO_DEPTH):0]   credits,
    output logic                          overflow_err
);

    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int CRED_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   win_id;
    logic              win_found;
    logic [ID_W-1:0]   sel_id;
    logic              grant;
    logic              pop_sat;

`ifdef ARB_LOCK_EN
    logic [ID_W-1:0]   owner;
`else
    // Lock requests have no effect in this build.
    logic              unused_lock;
    assign unused_lock = ^req_lock;
`endif

    // Round-robin search: first valid requester after the previous winner.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    // Requester actually served this cycle: the lock owner while locked.
    always_comb begin
        sel_id = win_id;
`ifdef ARB_LOCK_EN
        if (state == ST_LOCKED) begin
            sel_id = owner;
        end
`endif
    end

    // FSM output: one-hot ready, gated by a free credit and by the lock.
    always_comb begin
        req_ready = '0;
        if (credits != '0) begin
            if (state == ST_ARB) begin
                if (win_found) begin
                    req_ready[win_id] = 1'b1;
                end
            end
`ifdef ARB_LOCK_EN
            else if (req_valid[owner]) begin
                req_ready[owner] = 1'b1;
            end
`endif
        end
    end

    assign grant   = |req_ready;
    assign pop_sat = fifo_pop && (credits == CRED_W'(FIFO_DEPTH));

    // FSM next state: enter lock on a locking grant, leave on the owner's unlocking grant.
    always_comb begin
        state_nxt = state;
`ifdef ARB_LOCK_EN
        case (state)
            ST_ARB:    if (grant && req_lock[sel_id])  state_nxt = ST_LOCKED;
            ST_LOCKED: if (grant && !req_lock[sel_id]) state_nxt = ST_ARB;
            default:   state_nxt = ST_ARB;
        endcase
`else
        state_nxt = ST_ARB;
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_ARB;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef ARB_LOCK_EN
    // Remember which requester took the lock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner <= '0;
        end else if (state == ST_ARB && state_nxt == ST_LOCKED) begin
            owner <= sel_id;
        end
    end
`endif

    // Round-robin pointer follows every grant; reset value gives requester 0 first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= ID_W'(NUM_REQ - 1);
        end else if (grant) begin
            last_grant <= sel_id;
        end
    end

    // Registered FIFO write stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_wr_en <= 1'b0;
            fifo_din   <= '0;
            grant_id   <= '0;
        end else begin
            fifo_wr_en <= grant;
            if (grant) begin
                fifo_din <= req_data[int'(sel_id)*ENTRY_W +: ENTRY_W];
                grant_id <= sel_id;
            end
        end
    end

    // Credit counter: a grant reserves an entry, a pop returns one; a pop with all credits free is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits <= CRED_W'(FIFO_DEPTH);
        end else if (!pop_sat) begin
            case ({grant, fifo_pop})
                2'b10:   credits <= credits - CRED_W'(1);
                2'b01:   credits <= credits + CRED_W'(1);
                default: credits <= credits;
            endcase
        end
    end

    // Sticky error: spurious pop or a write presented to a full FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_err <= 1'b0;
        end else if (pop_sat || (fifo_wr_en && fifo_full)) begin
            overflow_err <= 1'b1;
        end
    end

endmodule
